// File: rtl/alu_pkg.sv
// Shared definitions for the shared-ALU controller: opcodes, the captured
// operation record, FSM states and the opcode legality check.
package alu_pkg;

  localparam int ALU_W = 16;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_ADDI = 4'b0010;
  localparam logic [3:0] OP_AND  = 4'b0011;
  localparam logic [3:0] OP_OR   = 4'b0100;
  localparam logic [3:0] OP_NOT  = 4'b0101;
  localparam logic [3:0] OP_SHL  = 4'b0110;
  localparam logic [3:0] OP_SHR  = 4'b0111;

  typedef struct packed {
    logic [3:0]       opcode;
    logic [ALU_W-1:0] a;
    logic [ALU_W-1:0] b;
  } alu_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // Opcodes 4'b1000..4'b1111 have no ALU function.
  function automatic logic is_legal_op(input logic [3:0] opcode);
    return (opcode <= OP_SHR);
  endfunction

endpackage

// File: rtl/alu_share_ctrl_rr_arb2.sv
// Two-way request picker with rr_last state; ALU_SHARE_FIXED_PRIO_EN selects
// fixed r0-first priority instead of round-robin.
module rr_arb2 (
  input  logic       clock,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output logic       gnt_id
);

  logic rr_last_q;
  logic rr_last_d;
  logic pick;

  always_comb begin
`ifdef ALU_SHARE_FIXED_PRIO_EN
    pick = ~req[0];
`else
    if (req == 2'b11) begin
      pick = ~rr_last_q;
    end else begin
      pick = ~req[0];
    end
`endif
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_gnt
    assign gnt[gi] = en & req[gi] & (pick == 1'(gi));
  end

  assign gnt_id = pick;

  always_comb begin
    rr_last_d = rr_last_q;
`ifndef ALU_SHARE_FIXED_PRIO_EN
    if (|gnt) begin
      rr_last_d = pick;
    end
`endif
  end

  // Reset to 1 so that r0 wins the first simultaneous request.
  always_ff @(posedge clock) begin
    if (reset) begin
      rr_last_q <= 1'b1;
    end else begin
      rr_last_q <= rr_last_d;
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one external ALU between two requesters; one op in flight, result
// returned on a valid/ready port. Build macro: ALU_SHARE_FIXED_PRIO_EN.
module alu_share_ctrl
  import alu_pkg::*;
#(
  parameter int W       = ALU_W,
  parameter int ALU_LAT = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         r0_valid,
  output logic         r0_ready,
  input  logic [3:0]   r0_opcode,
  input  logic [W-1:0] r0_a,
  input  logic [W-1:0] r0_b,
  input  logic         r1_valid,
  output logic         r1_ready,
  input  logic [3:0]   r1_opcode,
  input  logic [W-1:0] r1_a,
  input  logic [W-1:0] r1_b,
  output logic [3:0]   alu_opcode,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  input  logic [W-1:0] alu_out,
  input  logic         alu_ovf,
  input  logic         alu_zero,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [W-1:0] rsp_result,
  output logic         rsp_ovf,
  output logic         rsp_zero,
  output logic         rsp_err
);

  localparam logic [2:0] LAT_INIT = 3'(ALU_LAT);

  state_t       state_q, state_d;
  logic [2:0]   cnt_q, cnt_d;
  alu_op_t      alu_q, alu_d;
  logic         id_q, id_d;
  logic         rsp_valid_q, rsp_valid_d;
  logic [W-1:0] rsp_result_q, rsp_result_d;
  logic         rsp_ovf_q, rsp_ovf_d;
  logic         rsp_zero_q, rsp_zero_d;
  logic         rsp_err_q, rsp_err_d;

  logic [1:0]   req;
  logic [1:0]   gnt;
  logic         gnt_id;
  logic         arb_en;
  logic         accept;
  alu_op_t      sel_op;

  assign req    = {r1_valid, r0_valid};
  assign arb_en = (state_q == IDLE) && !reset;

  rr_arb2 u_arb (
    .clock  (clock),
    .reset  (reset),
    .en     (arb_en),
    .req    (req),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  assign accept   = |gnt;
  assign r0_ready = gnt[0];
  assign r1_ready = gnt[1];
  assign sel_op   = gnt_id ? {r1_opcode, r1_a, r1_b} : {r0_opcode, r0_a, r0_b};

  // The ALU-facing register doubles as the operand capture; it only loads on a
  // legal accept so the ALU inputs never move outside EXEC.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    alu_d        = alu_q;
    id_d         = id_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_ovf_d    = rsp_ovf_q;
    rsp_zero_d   = rsp_zero_q;
    rsp_err_d    = rsp_err_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          id_d = gnt_id;
          if (is_legal_op(sel_op.opcode)) begin
            alu_d   = sel_op;
            cnt_d   = LAT_INIT;
            state_d = EXEC;
          end else begin
            rsp_valid_d  = 1'b1;
            rsp_result_d = '0;
            rsp_ovf_d    = 1'b0;
            rsp_zero_d   = 1'b0;
            rsp_err_d    = 1'b1;
            state_d      = RESP;
          end
        end
      end
      EXEC: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          rsp_valid_d  = 1'b1;
          rsp_result_d = alu_out;
          rsp_ovf_d    = alu_ovf;
          rsp_zero_d   = alu_zero;
          rsp_err_d    = 1'b0;
          state_d      = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      alu_q        <= '0;
      id_q         <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_ovf_q    <= 1'b0;
      rsp_zero_q   <= 1'b0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      alu_q        <= alu_d;
      id_q         <= id_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_ovf_q    <= rsp_ovf_d;
      rsp_zero_q   <= rsp_zero_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign alu_opcode = alu_q.opcode;
  assign alu_a      = alu_q.a;
  assign alu_b      = alu_q.b;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = id_q;
  assign rsp_result = rsp_result_q;
  assign rsp_ovf    = rsp_ovf_q;
  assign rsp_zero   = rsp_zero_q;
  assign rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: behavioural ALU, vector table, scoreboard queue and
// hand-written arbitration, backpressure and reset sequences.
module tb_alu_share_ctrl;

  localparam int LAT = 1;

  logic        clock, reset;
  logic        r0_valid, r0_ready, r1_valid, r1_ready;
  logic [3:0]  r0_opcode, r1_opcode, alu_opcode;
  logic [15:0] r0_a, r0_b, r1_a, r1_b, alu_a, alu_b, alu_out;
  logic        alu_ovf, alu_zero;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_ovf, rsp_zero, rsp_err;
  logic [15:0] rsp_result;

  alu_share_ctrl #(.W(16), .ALU_LAT(LAT)) dut (
    .clock(clock), .reset(reset),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_opcode(r0_opcode), .r0_a(r0_a), .r0_b(r0_b),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_opcode(r1_opcode), .r1_a(r1_a), .r1_b(r1_b),
    .alu_opcode(alu_opcode), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .alu_ovf(alu_ovf), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_ovf(rsp_ovf), .rsp_zero(rsp_zero), .rsp_err(rsp_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Stand-in ALU; zero is only meaningful for sub.
  logic [15:0] alu_res;
  always_comb begin
    alu_res  = 16'h0000;
    alu_ovf  = 1'b0;
    alu_zero = 1'b0;
    case (alu_opcode)
      4'h0, 4'h2: begin
        alu_res = alu_a + alu_b;
        alu_ovf = (alu_a[15] == alu_b[15]) && (alu_res[15] != alu_a[15]);
      end
      4'h1: begin
        alu_res  = alu_a - alu_b;
        alu_ovf  = (alu_a[15] != alu_b[15]) && (alu_res[15] != alu_a[15]);
        alu_zero = (alu_res == 16'h0000);
      end
      4'h3: alu_res = alu_a & alu_b;
      4'h4: alu_res = alu_a | alu_b;
      4'h5: alu_res = ~alu_a;
      4'h6: alu_res = alu_a << alu_b[3:0];
      4'h7: alu_res = alu_a >> alu_b[3:0];
      default: alu_res = 16'h0000;
    endcase
  end
  assign alu_out = alu_res;

  typedef struct {
    logic        id;
    logic [3:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    logic        ovf;
    logic        zero;
    logic        err;
  } vec_t;

  typedef struct {
    logic        id;
    logic [15:0] res;
    logic        ovf;
    logic        zero;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic granted(input logic id);
    return id ? r1_ready : r0_ready;
  endfunction

  task automatic drive(input logic id, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    if (id) begin
      r1_valid = 1'b1; r1_opcode = op; r1_a = a; r1_b = b;
    end else begin
      r0_valid = 1'b1; r0_opcode = op; r0_a = a; r0_b = b;
    end
  endtask

  // Drives one request, waits (bounded) for its grant, returns at posedge+1.
  task automatic issue(input logic id, input logic [3:0] op, input logic [15:0] a,
                       input logic [15:0] b, input bit push, input exp_t e);
    int waited;
    @(negedge clock);
    drive(id, op, a, b);
    waited = 0;
    #1;
    while (granted(id) !== 1'b1 && waited < 20) begin
      @(negedge clock); #1; waited++;
    end
    check("accept", granted(id), 1'b1);
    if (push) sb.push_back(e);
    @(posedge clock); #1;
    if (id) r1_valid = 1'b0; else r0_valid = 1'b0;
  endtask

  // Called at posedge+1 of the handshake edge; waits for rsp_valid and compares.
  task automatic collect(input int exp_lat, input string tag);
    int   lat;
    exp_t e;
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 20) begin
      @(posedge clock); #1; lat++;
    end
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " ready_low_in_resp"}, {r1_ready, r0_ready}, 2'b00);
    total++;
    if (sb.size() == 0) begin
      $display("FAIL %s scoreboard: got no expected entry, required one", tag);
    end else begin
      passed++;
      e = sb.pop_front();
      check({tag, " id"},     rsp_id,     e.id);
      check({tag, " result"}, rsp_result, e.res);
      check({tag, " ovf"},    rsp_ovf,    e.ovf);
      check({tag, " zero"},   rsp_zero,   e.zero);
      check({tag, " err"},    rsp_err,    e.err);
    end
    $display("rsp %s: id=%0d result=%04h ovf=%0d zero=%0d err=%0d lat=%0d",
             tag, rsp_id, rsp_result, rsp_ovf, rsp_zero, rsp_err, lat);
  endtask

  task automatic retire(input string tag);
    rsp_ready = 1'b1;
    @(posedge clock); #1;
    check({tag, " retired"}, rsp_valid, 1'b0);
  endtask

  task automatic do_op(input vec_t v, input string tag);
    exp_t        e;
    logic [35:0] saved;
    logic        legal;
    e.id = v.id; e.res = v.res; e.ovf = v.ovf; e.zero = v.zero; e.err = v.err;
    legal = (v.op[3] == 1'b0);
    saved = {alu_opcode, alu_a, alu_b};
    rsp_ready = 1'b1;
    issue(v.id, v.op, v.a, v.b, 1'b1, e);
    if (legal) check({tag, " alu_drive"}, {alu_opcode, alu_a, alu_b}, {v.op, v.a, v.b});
    else       check({tag, " alu_hold"},  {alu_opcode, alu_a, alu_b}, saved);
    collect(legal ? LAT + 1 : 1, tag);
    retire(tag);
  endtask

  vec_t vecs[12];
  exp_t e;
  int   waited;
  logic gid, exp_gid;
  logic [15:0] held;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{1'b0, 4'h0, 16'h0003, 16'h0004, 16'h0007, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 4'h0, 16'h7FFF, 16'h0001, 16'h8000, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 4'h1, 16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 4'hA, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, 4'h3, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 4'h4, 16'h00F0, 16'h0F00, 16'h0FF0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 4'h5, 16'h00FF, 16'h0000, 16'hFF00, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 4'h6, 16'h0001, 16'h0004, 16'h0010, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 4'h7, 16'h8000, 16'h000F, 16'h0001, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 4'h1, 16'h0005, 16'h0007, 16'hFFFE, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 4'hF, 16'h1111, 16'h2222, 16'h0000, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{1'b1, 4'h2, 16'h0010, 16'h0020, 16'h0030, 1'b0, 1'b0, 1'b0};

    reset = 1'b1; rsp_ready = 1'b0;
    r0_valid = 1'b0; r0_opcode = 4'h0; r0_a = 16'h0; r0_b = 16'h0;
    r1_valid = 1'b0; r1_opcode = 4'h0; r1_a = 16'h0; r1_b = 16'h0;
    repeat (2) @(negedge clock);
    r0_valid = 1'b1; r1_valid = 1'b1;
    #1;
    check("reset ready", {r1_ready, r0_ready}, 2'b00);
    @(negedge clock);
    r0_valid = 1'b0; r1_valid = 1'b0;
    check("reset rsp_valid", rsp_valid, 1'b0);
    check("reset rsp_fields", {rsp_id, rsp_result, rsp_ovf, rsp_zero, rsp_err}, 20'h0);
    check("reset alu", {alu_opcode, alu_a, alu_b}, 36'h0);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) do_op(vecs[i], $sformatf("vec%0d", i));

    // Both requesters valid continuously; rr_last is 1 after vec11.
    @(negedge clock);
    rsp_ready = 1'b1;
    drive(1'b0, 4'h0, 16'h0001, 16'h0001);
    drive(1'b1, 4'h4, 16'h0002, 16'h0001);
    for (int k = 0; k < 4; k++) begin
      waited = 0;
      #1;
      while (!(r0_ready === 1'b1 || r1_ready === 1'b1) && waited < 20) begin
        @(negedge clock); #1; waited++;
      end
      if (k > 0) check($sformatf("rr%0d accept_gap", k), waited, 0);
      check($sformatf("rr%0d onehot", k), r0_ready & r1_ready, 1'b0);
      gid = r1_ready;
`ifdef ALU_SHARE_FIXED_PRIO_EN
      exp_gid = 1'b0;
`else
      exp_gid = k[0];
`endif
      check($sformatf("rr%0d grant", k), gid, exp_gid);
      e.id = gid; e.res = gid ? 16'h0003 : 16'h0002; e.ovf = 1'b0; e.zero = 1'b0; e.err = 1'b0;
      sb.push_back(e);
      @(posedge clock); #1;
      collect(LAT + 1, $sformatf("rr%0d", k));
      retire($sformatf("rr%0d", k));
    end
    r0_valid = 1'b0; r1_valid = 1'b0;

    // Backpressure: hold rsp_ready low while r1 waits.
    rsp_ready = 1'b0;
    e.id = 1'b0; e.res = 16'h0123; e.ovf = 1'b0; e.zero = 1'b0; e.err = 1'b0;
    issue(1'b0, 4'h0, 16'h0100, 16'h0023, 1'b1, e);
    drive(1'b1, 4'h1, 16'h0010, 16'h0001);
    collect(LAT + 1, "bp");
    held = rsp_result;
    for (int c = 0; c < 5; c++) begin
      @(posedge clock); #1;
      check($sformatf("bp hold%0d valid", c), rsp_valid, 1'b1);
      check($sformatf("bp hold%0d result", c), rsp_result, held);
      check($sformatf("bp hold%0d r1_ready", c), r1_ready, 1'b0);
    end
    retire("bp");
    check("bp next_accept", r1_ready, 1'b1);
    e.id = 1'b1; e.res = 16'h000F; e.ovf = 1'b0; e.zero = 1'b0; e.err = 1'b0;
    sb.push_back(e);
    @(posedge clock); #1;
    r1_valid = 1'b0;
    collect(LAT + 1, "bp_next");
    retire("bp_next");

    // Reset while the op is in EXEC: it must vanish.
    rsp_ready = 1'b1;
    issue(1'b0, 4'h0, 16'h0005, 16'h0005, 1'b0, e);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check("rst_exec rsp_valid", rsp_valid, 1'b0);
    check("rst_exec alu", {alu_opcode, alu_a, alu_b}, 36'h0);
    for (int c = 0; c < 5; c++) begin
      @(posedge clock); #1;
      check($sformatf("rst_exec quiet%0d", c), rsp_valid, 1'b0);
    end
    @(negedge clock);
    drive(1'b0, 4'h0, 16'h0101, 16'h0001);
    drive(1'b1, 4'h3, 16'h00FF, 16'h0F0F);
    #1;
    check("rst_exec r0_first", {r1_ready, r0_ready}, 2'b01);
    e.id = 1'b0; e.res = 16'h0102; e.ovf = 1'b0; e.zero = 1'b0; e.err = 1'b0;
    sb.push_back(e);
    @(posedge clock); #1;
    r0_valid = 1'b0; r1_valid = 1'b0;
    collect(LAT + 1, "rst_after");
    retire("rst_after");
    check("scoreboard empty", sb.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
